// File: rtl/axi_wr_arb_pkg.sv
// Shared state encoding and AXI constants for the two-requester AXI3 write arbiter.
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b01 ^ 2'b01;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Bufferable + modifiable
  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// AXI3 write channels (AW, W, B) between the arbiter (master) and the downstream slave.
interface axi_wr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_arbiter_rr_arb2.sv
// Two-way round-robin selector; the pointer moves past the winner only when update is high.
module rr_arb2 (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // ptr_q high means requester 1 currently has priority
  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (ptr_q) begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end else begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
    if (update && (gnt != 2'b00)) ptr_d = gnt[0];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI3 write arbiter for two burst requesters, one outstanding burst at a time.
// Optional B-response watchdog enabled by defining AXI_WR_ARB_TIMEOUT_EN.
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [1:0]            req_valid,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*4-1:0]        req_len,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [2*DATA_W/8-1:0] req_wstrb,
  output logic [1:0]            req_wready,
  output logic [1:0]            req_done,
  output logic [1:0]            req_bresp,
  output logic [7:0]            err_cnt,
  axi_wr_arbiter_if.master      m_axi
);

  localparam int         STRB_W  = DATA_W / 8;
  localparam logic [2:0] AW_SIZE = 3'($clog2(STRB_W));

  state_e            state_q, state_d;
  logic              g_q, g_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [7:0]        err_q, err_d;
  logic [1:0]        ready_q, ready_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        gnt;
  logic              grant;
  logic              wlast;

`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign grant = (state_q == ST_IDLE) && (req_valid != 2'b00);

  rr_arb2 u_rr (
    .aclk   (aclk),
    .areset (areset),
    .req    (req_valid),
    .update (grant),
    .gnt    (gnt)
  );

  assign wlast = (state_q == ST_DATA) && (beat_q == {4'b0000, len_q});

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    bresp_d = bresp_q;
    err_d   = err_q;
    ready_d = 2'b00;
    done_d  = 2'b00;
`ifdef AXI_WR_ARB_TIMEOUT_EN
    tmo_d   = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          g_d     = gnt[1];
          addr_d  = gnt[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          len_d   = gnt[1] ? req_len[7:4] : req_len[3:0];
          beat_d  = 8'd0;
          ready_d = gnt;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi.awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m_axi.wready) begin
          beat_d = beat_q + 8'd1;
          if (wlast) begin
            beat_d  = 8'd0;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (m_axi.bvalid) begin
          bresp_d = m_axi.bresp;
          done_d  = onehot2(g_q);
          if (m_axi.bresp != RESP_OKAY) err_d = sat_inc8(err_q);
          state_d = ST_IDLE;
        end
`ifdef AXI_WR_ARB_TIMEOUT_EN
        // Watchdog: give up on a missing B response and report it as a slave error
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          bresp_d = RESP_SLVERR;
          done_d  = onehot2(g_q);
          err_d   = sat_inc8(err_q);
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      g_q     <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      bresp_q <= '0;
      err_q   <= '0;
      ready_q <= '0;
      done_q  <= '0;
`ifdef AXI_WR_ARB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      g_q     <= g_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      bresp_q <= bresp_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef AXI_WR_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign m_axi.awid    = 4'd0;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = AW_SIZE;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 2'b00;
  assign m_axi.awcache = CACHE_BUF_MOD;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awvalid = (state_q == ST_ADDR);

  assign m_axi.wvalid = (state_q == ST_DATA);
  assign m_axi.wlast  = wlast;
  assign m_axi.wdata  = g_q ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign m_axi.wstrb  = g_q ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];
  assign m_axi.bready = (state_q == ST_RESP);

  assign req_wready = ((state_q == ST_DATA) && m_axi.wready) ? onehot2(g_q) : 2'b00;
  assign req_ready  = ready_q;
  assign req_done   = done_q;
  assign req_bresp  = bresp_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: vector table of single bursts plus hand-written multi-cycle sequences.
module tb_axi_wr_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [7:0]  S0 = 8'h0F;
  localparam logic [7:0]  S1 = 8'hF0;

  logic                  aclk;
  logic                  areset;
  logic [1:0]            req_valid;
  logic [2*ADDR_W-1:0]   req_addr;
  logic [7:0]            req_len;
  logic [1:0]            req_ready;
  logic [2*DATA_W-1:0]   req_wdata;
  logic [2*DATA_W/8-1:0] req_wstrb;
  logic [1:0]            req_wready;
  logic [1:0]            req_done;
  logic [1:0]            req_bresp;
  logic [7:0]            err_cnt;

  axi_wr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_wready (req_wready),
    .req_done   (req_done),
    .req_bresp  (req_bresp),
    .err_cnt    (err_cnt),
    .m_axi      (axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          rid;
    logic [31:0] addr;
    logic [3:0]  len;
    int          aw_stall;
    bit          wtoggle;
    logic [1:0]  bresp;
    int          exp_beats;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic run_burst(input vec_t v);
    logic [1:0] oh;
    int beats;
    int cyc;
    oh = (v.rid == 1) ? 2'b10 : 2'b01;
    if (v.rid == 1) begin
      req_addr[63:32] = v.addr;
      req_len[7:4]    = v.len;
    end else begin
      req_addr[31:0]  = v.addr;
      req_len[3:0]    = v.len;
    end
    req_valid = oh;
    tick();
    chk("req_ready_grant", req_ready, oh);
    chk("awvalid_first", axi.awvalid, 1'b1);
    chk("awaddr", axi.awaddr, v.addr);
    chk("awlen", axi.awlen, v.len);
    req_valid = 2'b00;
    for (int i = 1; i < v.aw_stall; i++) begin
      tick();
      chk("awvalid_stall", axi.awvalid, 1'b1);
      chk("awaddr_stall", axi.awaddr, v.addr);
      chk("awlen_stall", axi.awlen, v.len);
    end
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    chk("awvalid_drop", axi.awvalid, 1'b0);
    chk("req_ready_pulse", req_ready, 2'b00);
    beats = 0;
    cyc   = 0;
    while (beats < v.exp_beats && cyc < 200) begin
      axi.wready = v.wtoggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("wvalid", axi.wvalid, 1'b1);
      chk("wlast", axi.wlast, (beats == v.exp_beats - 1));
      if (axi.wready) begin
        chk("req_wready", req_wready, oh);
        chk("wdata", axi.wdata, (v.rid == 1) ? D1 : D0);
        chk("wstrb", axi.wstrb, (v.rid == 1) ? S1 : S0);
        beats++;
      end else begin
        chk("req_wready_stall", req_wready, 2'b00);
      end
      tick();
      cyc++;
    end
    axi.wready = 1'b0;
    chk("data_beats", beats, v.exp_beats);
    chk("wvalid_resp", axi.wvalid, 1'b0);
    chk("bready", axi.bready, 1'b1);
    axi.bvalid = 1'b1;
    axi.bresp  = v.bresp;
    #1;
    chk("req_done_early", req_done, 2'b00);
    tick();
    axi.bvalid = 1'b0;
    chk("req_done", req_done, oh);
    chk("req_bresp", req_bresp, v.bresp);
    chk("err_cnt", err_cnt, v.exp_err);
    chk("bready_idle", axi.bready, 1'b0);
    tick();
    chk("req_done_pulse", req_done, 2'b00);
  endtask

  task automatic fast_err_burst(input int rid);
    int k;
    req_len   = 8'h00;
    req_valid = (rid == 1) ? 2'b10 : 2'b01;
    tick();
    req_valid = 2'b00;
    k = 0;
    while (!axi.bready && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) chk("fast_resp_timeout", k, 0);
    axi.bvalid = 1'b1;
    axi.bresp  = 2'b10;
    tick();
    axi.bvalid = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int grants;
    int gseq[4];
    int done0;
    int done1;
    bit outstanding;

    vecs[0] = '{0, 32'h1000_0000, 4'd15, 0, 1'b0, 2'b00, 16, 8'd0};
    vecs[1] = '{1, 32'h2000_0040, 4'd7,  0, 1'b1, 2'b00, 8,  8'd0};
    vecs[2] = '{0, 32'h3000_0000, 4'd3,  5, 1'b0, 2'b00, 4,  8'd0};
    vecs[3] = '{1, 32'h4000_0000, 4'd0,  0, 1'b0, 2'b10, 1,  8'd1};
    vecs[4] = '{0, 32'h5000_0000, 4'd1,  0, 1'b0, 2'b10, 2,  8'd2};
    vecs[5] = '{1, 32'h6000_0000, 4'd0,  0, 1'b0, 2'b10, 1,  8'd3};
    vecs[6] = '{0, 32'h7000_0100, 4'd2,  0, 1'b0, 2'b01, 3,  8'd4};

    areset      = 1'b1;
    req_valid   = 2'b11;
    req_addr    = {32'hDEAD_0000, 32'hBEEF_0000};
    req_len     = 8'hFF;
    req_wdata   = {D1, D0};
    req_wstrb   = {S1, S0};
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_req_wready", req_wready, 2'b00);
    chk("rst_req_done", req_done, 2'b00);
    chk("rst_req_bresp", req_bresp, 2'b00);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_awaddr", axi.awaddr, 32'd0);
    chk("rst_awlen", axi.awlen, 4'd0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_wlast", axi.wlast, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("awsize", axi.awsize, 3'd3);
    chk("awburst", axi.awburst, 2'b01);
    chk("awcache", axi.awcache, 4'b0011);
    req_valid = 2'b00;
    areset    = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Error counter: 4 so far; 250 more reaches 254, 251 reaches 255, then holds
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      fast_err_burst(i % 2);
      if (i == 250) chk("err_cnt_254", err_cnt, 8'd254);
      if (i == 251) chk("err_cnt_255", err_cnt, 8'd255);
    end
    chk("err_cnt_sat", err_cnt, 8'd255);
    chk("bresp_err", req_bresp, 2'b10);

    // Reset in the middle of a DATA phase
    req_len[7:4] = 4'd7;
    req_valid    = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    chk("mid_wvalid_before", axi.wvalid, 1'b1);
    #2 areset = 1'b1;
    #1;
    chk("mid_awvalid", axi.awvalid, 1'b0);
    chk("mid_awaddr", axi.awaddr, 32'd0);
    chk("mid_awlen", axi.awlen, 4'd0);
    chk("mid_wvalid", axi.wvalid, 1'b0);
    chk("mid_wlast", axi.wlast, 1'b0);
    chk("mid_req_wready", req_wready, 2'b00);
    chk("mid_bready", axi.bready, 1'b0);
    chk("mid_req_done", req_done, 2'b00);
    chk("mid_req_ready", req_ready, 2'b00);
    chk("mid_err_cnt", err_cnt, 8'd0);
    chk("mid_req_bresp", req_bresp, 2'b00);
    tick();
    chk("mid_done_rst", req_done, 2'b00);
    areset      = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", req_done, 2'b00);
      chk("post_rst_wvalid", axi.wvalid, 1'b0);
    end

    // Both requesters hold req_valid; grants must alternate starting with 0
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    req_len     = 8'h33;
    req_valid   = 2'b11;
    grants      = 0;
    done0       = 0;
    done1       = 0;
    outstanding = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (axi.bvalid) begin
        axi.bvalid  = 1'b0;
        outstanding = 1'b0;
      end else if (axi.bready) begin
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b00;
      end
      if (req_done[0]) done0++;
      if (req_done[1]) done1++;
      if (req_ready != 2'b00) begin
        chk("no_early_grant", outstanding, 1'b0);
        if (grants < 4) gseq[grants] = int'(req_ready[1]);
        grants++;
        outstanding = 1'b1;
        if (grants == 4) req_valid = 2'b00;
      end
      if (grants >= 4 && !outstanding && (done0 + done1) == 4) break;
      tick();
    end
    axi.bvalid = 1'b0;
    chk("alt_grants", grants, 4);
    chk("alt_g0", gseq[0], 0);
    chk("alt_g1", gseq[1], 1);
    chk("alt_g2", gseq[2], 0);
    chk("alt_g3", gseq[3], 1);
    chk("alt_done0", done0, 2);
    chk("alt_done1", done1, 2);
    chk("alt_err_cnt", err_cnt, 8'd0);
    tick();

`ifdef AXI_WR_ARB_TIMEOUT_EN
    begin : timeout_seq
      int rc;
      req_len   = 8'h00;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      rc = 0;
      for (int k = 0; k < 10 && !axi.bready; k++) tick();
      while (axi.bready && rc < 100) begin
        chk("tmo_done_early", req_done, 2'b00);
        rc++;
        tick();
      end
      chk("tmo_resp_cycles", rc, 16);
      chk("tmo_done", req_done, 2'b01);
      chk("tmo_bresp", req_bresp, 2'b10);
      chk("tmo_err_cnt", err_cnt, 8'd1);
      tick();
      chk("tmo_done_pulse", req_done, 2'b00);
    end
`endif

    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
